// File: rtl/debug_pkg.sv
// ============================================================================
//  Module   : debug_pkg
//  Brief    : Shared definitions for the MIPS debug unit (RX and TX sides):
//             command byte encodings and the RX execution-control state set.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package debug_pkg;

  // Command bytes received over the UART
  localparam logic [7:0] CMD_STEP  = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;
  localparam logic [7:0] CMD_RESET = 8'h03;

  // Execution-control states of the receive FSM
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    RST_P = 3'd3,
    SEND  = 3'd4
  } state_e;

  // True when the byte is one of the recognised commands
  function automatic logic is_command(input logic [7:0] b);
    return (b == CMD_STEP) || (b == CMD_RUN) || (b == CMD_RESET);
  endfunction

endpackage : debug_pkg

`default_nettype wire

// File: rtl/debugger_rx.sv
// ============================================================================
//  Module   : debugger_rx
//  Brief    : Command-receive / execution-control FSM of the MIPS debug unit.
//             Pops one command byte at a time from the UART RX FIFO, drives
//             the pipeline clock/reset for RUN, STEP and RESET, then asks the
//             TX side to dump the pipeline state and waits for it to finish.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module debugger_rx
  import debug_pkg::*;
#(
  parameter int RST_CYCLES = 4   // software pipeline reset length, even, >= 2
) (
  input  logic       clk,
  input  logic       global_reset,
  input  logic [7:0] r_data,
  input  logic       rx_empty,
  input  logic       program_finished,
  input  logic       data_sent,
  output logic       rd_uart,
  output logic       pipeline_reset,
  output logic       pipeline_clk,
  output logic       send_data
);

  localparam int                CNT_W      = $clog2(RST_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);

  state_e           r_state;
  logic             r_pclk;
  logic             r_prst;
  logic             r_send;
  logic [CNT_W-1:0] r_cnt;
  logic             w_pop;

  // A byte is consumed only from IDLE, and never while reset is asserted
  assign w_pop = (r_state == IDLE) & ~rx_empty & ~global_reset;

  assign rd_uart        = w_pop;
  assign pipeline_clk   = r_pclk;
  assign pipeline_reset = r_prst;
  assign send_data      = r_send;

  // Execution-control FSM: command decode, pipeline clock/reset generation, TX handshake
  always_ff @(posedge clk) begin
    if (global_reset) begin
      r_state <= IDLE;
      r_pclk  <= 1'b0;
      r_prst  <= 1'b1;          // pipeline held in reset until the first free edge
      r_send  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pclk <= 1'b0;
          r_prst <= 1'b0;
          r_send <= 1'b0;
          if (w_pop && is_command(r_data)) begin
            // Every command starts with a rising pipeline clock edge
            r_pclk <= 1'b1;
            r_cnt  <= '0;
            case (r_data)
              CMD_STEP: r_state <= STEP;
              CMD_RUN:  r_state <= RUN;
              default: begin
                // CMD_RESET: pipeline reset asserted together with the first edge
                r_state <= RST_P;
                r_prst  <= 1'b1;
              end
            endcase
          end
          // Unrecognised bytes are popped and dropped; stay in IDLE
        end

        RUN: begin
          if (program_finished) begin
            r_pclk  <= 1'b0;
            r_send  <= 1'b1;
            r_state <= SEND;
          end else begin
            r_pclk  <= ~r_pclk;  // clk/2 for the pipeline
          end
        end

        STEP: begin
          // Single high cycle already delivered on entry
          r_pclk  <= 1'b0;
          r_send  <= 1'b1;
          r_state <= SEND;
        end

        RST_P: begin
          if (r_cnt == c_CNT_LAST) begin
            r_prst  <= 1'b0;
            r_pclk  <= 1'b0;
            r_send  <= 1'b1;
            r_state <= SEND;
          end else begin
            r_cnt   <= r_cnt + c_CNT_ONE;
            r_pclk  <= ~r_pclk;  // RST_CYCLES/2 rising edges under reset
          end
        end

        SEND: begin
          if (data_sent) begin
            r_send  <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
          r_pclk  <= 1'b0;
          r_prst  <= 1'b0;
          r_send  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule : debugger_rx

`default_nettype wire

// File: tb/tb_debugger_rx.sv
// ============================================================================
//  Module   : tb_debugger_rx
//  Brief    : Self-checking bench for debugger_rx: directed command scenarios
//             with hand-counted expectations, then randomized traffic checked
//             every cycle against a behavioural model of the command rules.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_debugger_rx;

  localparam int RST_CYCLES = 4;

  // Model operation codes (what the debug unit is doing, not the RTL encoding)
  localparam int OP_IDLE = 0;
  localparam int OP_RUN  = 1;
  localparam int OP_STEP = 2;
  localparam int OP_RSTP = 3;
  localparam int OP_SEND = 4;

  logic       clk = 1'b0;
  logic       global_reset = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rx_empty = 1'b1;
  logic       program_finished = 1'b0;
  logic       data_sent = 1'b0;
  logic       rd_uart;
  logic       pipeline_reset;
  logic       pipeline_clk;
  logic       send_data;

  int checks = 0;
  int errors = 0;

  byte unsigned q[$];          // emulated UART RX FIFO contents

  int m_op    = OP_IDLE;       // model: current operation
  int m_k     = 0;             // model: edges elapsed since the command was sampled
  bit m_por   = 1'b1;          // model: pipeline reset from global reset
  bit m_valid = 1'b0;          // model has seen a reset edge

  bit cnt_en   = 1'b0;
  int cnt_pclk = 0;
  int cnt_prst = 0;
  int cnt_rd   = 0;
  int cnt_send = 0;

  debugger_rx #(.RST_CYCLES(RST_CYCLES)) dut (
    .clk              (clk),
    .global_reset     (global_reset),
    .r_data           (r_data),
    .rx_empty         (rx_empty),
    .program_finished (program_finished),
    .data_sent        (data_sent),
    .rd_uart          (rd_uart),
    .pipeline_reset   (pipeline_reset),
    .pipeline_clk     (pipeline_clk),
    .send_data        (send_data)
  );

  always #50 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // RX FIFO emulation: pop on the strobe seen at the edge, present the new head
  initial begin
    logic pop;
    forever begin
      @(posedge clk);
      pop = rd_uart;
      #1;
      if (pop && q.size() > 0) void'(q.pop_front());
      rx_empty = (q.size() == 0);
      r_data   = (q.size() > 0) ? q[0] : 8'h00;
    end
  end

  // Behavioural model: advance by the command rules on each clock edge
  always @(posedge clk) begin
    if (global_reset) begin
      m_op = OP_IDLE; m_k = 0; m_por = 1'b1; m_valid = 1'b1;
    end else begin
      m_por = 1'b0;
      if (m_op == OP_IDLE) begin
        if (!rx_empty) begin
          m_k = 0;
          if (r_data == 8'h01)      m_op = OP_STEP;
          else if (r_data == 8'h02) m_op = OP_RUN;
          else if (r_data == 8'h03) m_op = OP_RSTP;
        end
      end else if (m_op == OP_RUN) begin
        if (program_finished) m_op = OP_SEND;
        else m_k++;
      end else if (m_op == OP_STEP) begin
        m_op = OP_SEND;
      end else if (m_op == OP_RSTP) begin
        m_k++;
        if (m_k == RST_CYCLES) m_op = OP_SEND;
      end else begin
        if (data_sent) m_op = OP_IDLE;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("rd_uart", rd_uart, (m_op == OP_IDLE) && !rx_empty && !global_reset);
      chk("pipeline_reset", pipeline_reset, m_por || (m_op == OP_RSTP));
      chk("pipeline_clk", pipeline_clk,
          ((m_op == OP_RUN || m_op == OP_RSTP) && (m_k % 2 == 0)) || (m_op == OP_STEP));
      chk("send_data", send_data, m_op == OP_SEND);
    end
  end

  // Pulse/level counters for the directed scenarios
  always @(negedge clk) begin
    if (cnt_en) begin
      if (pipeline_clk === 1'b1)   cnt_pclk++;
      if (pipeline_reset === 1'b1) cnt_prst++;
      if (rd_uart === 1'b1)        cnt_rd++;
      if (send_data === 1'b1)      cnt_send++;
    end
  end

  task automatic clear_counts();
    cnt_pclk = 0; cnt_prst = 0; cnt_rd = 0; cnt_send = 0;
    cnt_en = 1'b1;
  endtask

  task automatic wait_send(input string name);
    int n = 0;
    while (send_data !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(name, send_data, 1'b1);
  endtask

  task automatic finish_send(input string name);
    data_sent = 1'b1;
    tick();
    data_sent = 1'b0;
    chk(name, send_data, 1'b0);
  endtask

  initial begin
    int r;
    // Global reset for two cycles, then release
    global_reset = 1'b1;
    repeat (2) tick();
    chk("reset pipeline_reset", pipeline_reset, 1'b1);
    chk("reset send_data", send_data, 1'b0);
    chk("reset pipeline_clk", pipeline_clk, 1'b0);
    global_reset = 1'b0;
    tick();
    chk("release pipeline_reset", pipeline_reset, 1'b0);

    // STEP: exactly one pipeline clock high cycle
    clear_counts();
    q.push_back(8'h01);
    wait_send("step send timeout");
    cnt_en = 1'b0;
    chk_int("step pclk cycles", cnt_pclk, 1);
    chk_int("step pops", cnt_rd, 1);
    finish_send("step send clear");

    // RESET: pipeline_reset for RST_CYCLES cycles with RST_CYCLES/2 clock pulses
    clear_counts();
    q.push_back(8'h03);
    wait_send("reset send timeout");
    cnt_en = 1'b0;
    chk_int("reset prst cycles", cnt_prst, 4);
    chk_int("reset pclk cycles", cnt_pclk, 2);
    finish_send("reset send clear");

    // Invalid byte: popped once, nothing else happens
    clear_counts();
    q.push_back(8'h55);
    repeat (8) tick();
    cnt_en = 1'b0;
    chk_int("invalid pops", cnt_rd, 1);
    chk_int("invalid send cycles", cnt_send, 0);
    chk_int("invalid pclk cycles", cnt_pclk, 0);

    // RUN: program_finished after a few cycles stops the clock and requests send
    q.push_back(8'h02);
    repeat (6) tick();
    program_finished = 1'b1;
    tick();
    program_finished = 1'b0;
    chk("run end send_data", send_data, 1'b1);
    chk("run end pclk", pipeline_clk, 1'b0);
    finish_send("run send clear");

    // Global reset mid-RUN
    q.push_back(8'h02);
    repeat (4) tick();
    global_reset = 1'b1;
    tick();
    chk("midrun prst", pipeline_reset, 1'b1);
    chk("midrun pclk", pipeline_clk, 1'b0);
    global_reset = 1'b0;
    tick();

    // Global reset mid-SEND
    q.push_back(8'h01);
    wait_send("midsend send timeout");
    global_reset = 1'b1;
    tick();
    chk("midsend send_data", send_data, 1'b0);
    chk("midsend prst", pipeline_reset, 1'b1);
    global_reset = 1'b0;
    tick();

    // Randomized traffic checked by the model every cycle
    repeat (3000) begin
      tick();
      program_finished = ($urandom_range(0, 7) == 0);
      data_sent        = ($urandom_range(0, 3) == 0);
      global_reset     = ($urandom_range(0, 199) == 0);
      if (q.size() < 2 && $urandom_range(0, 5) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 3)      q.push_back(8'h01);
        else if (r < 6) q.push_back(8'h02);
        else if (r < 8) q.push_back(8'h03);
        else            q.push_back(8'($urandom_range(0, 255)));
      end
    end
    global_reset = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_debugger_rx

`default_nettype wire
